// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Purpose:
//   * Operand forwarding select for the execute stage (MEM over WB, r0 never).
//   * Load-use bubble insertion (LOAD_LAT bubbles per hazard), tolerant of
//     long stalls (I$/D$ miss, divider) interleaved with the bubbles.
//   * Exception flush from the memory stage, deferred while a long stall is
//     in progress so that the flush is never lost against a frozen pipeline.
//   * Saturating count of cycles in which fetch was stalled.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_cache_stall/d_cache_stall/
//   div_stall                         long-stall requests
//   rsD, rtD, rsE, rtE                source registers in decode / execute
//   reg_write_en{E,M,W}, reg_write{E,M,W}  destination write enable / index
//   mem_read_enE, mem_read_enM        load in execute / memory
//   exceptionM                        one-cycle exception pulse from MEM
//   stall{F,D,E,M,W}                  pipeline-register hold
//   flush{F,D,E,M}                    pipeline-register clear
//   forward_aE, forward_bE            00 none, 01 from MEM, 10 from WB
//   stall_cnt                         saturating count of stallF cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cache_stall,
    input  logic              d_cache_stall,
    input  logic              div_stall,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic              reg_write_enE,
    input  logic              reg_write_enM,
    input  logic              reg_write_enW,
    input  logic [REG_AW-1:0] reg_writeE,
    input  logic [REG_AW-1:0] reg_writeM,
    input  logic [REG_AW-1:0] reg_writeW,
    input  logic              mem_read_enE,
    input  logic              mem_read_enM,
    input  logic              exceptionM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic [1:0]        forward_aE,
    output logic [1:0]        forward_bE,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LU     = 2'd1;
    localparam logic [1:0] S_FPEND  = 2'd2;

    // Bubbles still owed after the hazard-detect cycle (which is itself one).
    localparam logic [1:0] LAT_M1   = 2'(LOAD_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       bub_q, bub_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic long_stall;
    logic lu_hit;
    logic lu_stall;
    logic flush_now;
    logic stall_any;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              we_m,
        input logic              ld_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              we_w,
        input logic [REG_AW-1:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            // A load in MEM has no result yet, so only WB can supply it.
            if (we_m && !ld_m && dst_m == src)
                sel = 2'b01;
            else if (we_w && dst_w == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        long_stall = i_cache_stall | d_cache_stall | div_stall;
        lu_hit     = mem_read_enE & reg_write_enE & (reg_writeE != '0) &
                     ((reg_writeE == rsD) | (reg_writeE == rtD));
        // A flush can only land when nothing is frozen; a pending one waits.
        flush_now  = ~long_stall & (exceptionM | (state_q == S_FPEND));

        state_d  = state_q;
        bub_d    = bub_q;
        lu_stall = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exceptionM) begin
                    state_d = long_stall ? S_FPEND : S_IDLE;
                end else if (lu_hit) begin
                    lu_stall = 1'b1;
                    // Under a long stall the hazard stays visible (pipeline is
                    // held), so it is simply taken once the stall clears.
                    if (!long_stall && LAT_M1 != 2'd0) begin
                        state_d = S_LU;
                        bub_d   = LAT_M1;
                    end
                end
            end
            S_LU: begin
                if (exceptionM) begin
                    state_d = long_stall ? S_FPEND : S_IDLE;
                    bub_d   = 2'd0;
                end else begin
                    lu_stall = 1'b1;
                    // bub_q counts bubbles left including this cycle's.
                    if (!long_stall) begin
                        if (bub_q <= 2'd1) begin
                            state_d = S_IDLE;
                            bub_d   = 2'd0;
                        end else begin
                            bub_d = 2'(bub_q - 2'd1);
                        end
                    end
                end
            end
            S_FPEND: begin
                if (!long_stall)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                bub_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_any  = (long_stall | lu_stall) & ~flush_now & ~rst;
        stallF     = stall_any;
        stallD     = stall_any;
        stallE     = stall_any;
        stallM     = stall_any;
        stallW     = d_cache_stall & ~rst;
        flushF     = flush_now & ~rst;
        flushD     = flush_now & ~rst;
        flushM     = flush_now & ~rst;
        // Bubble: the held decode instruction must not also advance into E.
        flushE     = (flush_now | (lu_stall & ~long_stall)) & ~rst;
        forward_aE = rst ? 2'b00 : fwd_sel(rsE, reg_write_enM, mem_read_enM,
                                           reg_writeM, reg_write_enW, reg_writeW);
        forward_bE = rst ? 2'b00 : fwd_sel(rtE, reg_write_enM, mem_read_enM,
                                           reg_writeM, reg_write_enW, reg_writeW);
        stall_cnt_d = stall_cnt_q;
        if (stall_any && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bub_q       <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_q       <= bub_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: dut (LOAD_LAT=2, CNT_W=32) and dut2 (LOAD_LAT=1, CNT_W=3)
// share all inputs; dut2 exercises single-bubble hazards and counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_cache_stall, d_cache_stall, div_stall;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic       reg_write_enE, reg_write_enM, reg_write_enW;
    logic [4:0] reg_writeE, reg_writeM, reg_writeW;
    logic       mem_read_enE, mem_read_enM, exceptionM;

    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM;
    logic [1:0]  forward_aE, forward_bE;
    logic [31:0] stall_cnt;

    logic        s2F, s2D, s2E, s2M, s2W;
    logic        f2F, f2D, f2E, f2M;
    logic [1:0]  fa2, fb2;
    logic [2:0]  cnt2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall), .div_stall(div_stall),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM), .reg_write_enW(reg_write_enW),
        .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .mem_read_enE(mem_read_enE), .mem_read_enM(mem_read_enM), .exceptionM(exceptionM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forward_aE(forward_aE), .forward_bE(forward_bE), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst),
        .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall), .div_stall(div_stall),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM), .reg_write_enW(reg_write_enW),
        .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .mem_read_enE(mem_read_enE), .mem_read_enM(mem_read_enM), .exceptionM(exceptionM),
        .stallF(s2F), .stallD(s2D), .stallE(s2E), .stallM(s2M), .stallW(s2W),
        .flushF(f2F), .flushD(f2D), .flushE(f2E), .flushM(f2M),
        .forward_aE(fa2), .forward_bE(fb2), .stall_cnt(cnt2)
    );

    wire [4:0] stv  = {stallF, stallD, stallE, stallM, stallW};
    wire [3:0] flv  = {flushF, flushD, flushE, flushM};
    wire [4:0] stv2 = {s2F, s2D, s2E, s2M, s2W};
    wire [3:0] flv2 = {f2F, f2D, f2E, f2M};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        i_cache_stall = 0; d_cache_stall = 0; div_stall = 0;
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        reg_write_enE = 0; reg_write_enM = 0; reg_write_enW = 0;
        reg_writeE = 0; reg_writeM = 0; reg_writeW = 0;
        mem_read_enE = 0; mem_read_enM = 0; exceptionM = 0;
    endtask

    task automatic load_hit(input logic [4:0] r, input bit use_rt);
        reg_write_enE = 1; mem_read_enE = 1; reg_writeE = r;
        if (use_rt) rtD = r; else rsD = r;
    endtask

    // Advance to the next falling edge; inputs are then changed and outputs
    // are sampled 2 time units later, well clear of the rising edge.
    task automatic nxt;
        @(negedge clk);
    endtask

    initial begin
        // ---- reset: outputs quiet even with active-looking inputs
        rst = 1; clr;
        rsE = 3; reg_write_enM = 1; reg_writeM = 3; d_cache_stall = 1; exceptionM = 1;
        #2;
        chk("rst_stall", stv, 0);
        chk("rst_flush", flv, 0);
        chk("rst_fwd_a", forward_aE, 0);
        chk("rst_cnt", stall_cnt, 0);
        nxt; rst = 0; clr; #2;
        chk("idle_stall", stv, 0);

        // ---- forwarding
        nxt;
        rsE = 3; rtE = 3; reg_write_enM = 1; reg_writeM = 3; reg_write_enW = 1; reg_writeW = 3; #2;
        chk("fwd_a_mem", forward_aE, 2'b01);
        chk("fwd_b_mem", forward_bE, 2'b01);
        mem_read_enM = 1; #1;
        chk("fwd_a_ldM_wb", forward_aE, 2'b10);
        chk("fwd_b_ldM_wb", forward_bE, 2'b10);
        rsE = 0; #1;
        chk("fwd_a_r0", forward_aE, 2'b00);
        chk("fwd_b_keep", forward_bE, 2'b10);
        reg_write_enW = 0; #1;
        chk("fwd_b_none", forward_bE, 2'b00);
        mem_read_enM = 0; reg_writeM = 4; reg_write_enW = 1; #1;
        chk("fwd_b_wb_only", forward_bE, 2'b10);
        chk("fwd_stall0", stv, 0);

        // ---- load-use, LOAD_LAT=2 (dut) and 1 (dut2)
        nxt; clr; load_hit(5, 0); #2;
        chk("lu1_stall", stv, 5'b11110);
        chk("lu1_flush", flv, 4'b0010);
        chk("lu1_stall2", stv2, 5'b11110);
        nxt; clr; #2;
        chk("lu2_stall", stv, 5'b11110);
        chk("lu2_flush", flv, 4'b0010);
        chk("lu2_stall2", stv2, 5'b00000);
        nxt; #2;
        chk("lu3_stall", stv, 0);
        chk("lu3_flush", flv, 0);
        chk("lu3_cnt", stall_cnt, 2);
        chk("lu3_cnt2", cnt2, 1);

        // ---- load-use via rtD with a 3-cycle divider stall on bubble 2
        nxt; clr; load_hit(7, 1); #2;
        chk("lud1_stall", stv, 5'b11110);
        chk("lud1_flush", flv, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            nxt; clr; div_stall = 1; #2;
            chk("lud_div_stall", stv, 5'b11110);
            chk("lud_div_flush", flv, 4'b0000);
        end
        nxt; clr; #2;
        chk("lud5_stall", stv, 5'b11110);
        chk("lud5_flush", flv, 4'b0010);
        chk("lud5_stall2", stv2, 0);
        nxt; #2;
        chk("lud6_stall", stv, 0);
        chk("lud6_flush", flv, 0);
        chk("lud6_cnt", stall_cnt, 7);
        chk("lud6_cnt2", cnt2, 5);

        // ---- exception under a 4-cycle D$ stall
        nxt; clr; exceptionM = 1; d_cache_stall = 1; #2;
        chk("exd1_stall", stv, 5'b11111);
        chk("exd1_flush", flv, 0);
        for (int i = 0; i < 3; i++) begin
            nxt; clr; d_cache_stall = 1; #2;
            chk("exd_hold_stall", stv, 5'b11111);
            chk("exd_hold_flush", flv, 0);
        end
        nxt; clr; #2;
        chk("exd5_flush", flv, 4'b1111);
        chk("exd5_stall", stv, 0);
        nxt; #2;
        chk("exd6_flush", flv, 0);
        chk("exd6_cnt", stall_cnt, 11);
        chk("exd6_cnt2_sat", cnt2, 7);

        // ---- load into r0 is not a hazard
        nxt; clr; reg_write_enE = 1; mem_read_enE = 1; reg_writeE = 0; rsD = 0; #2;
        chk("lu_r0_stall", stv, 0);

        // ---- exception coincident with a load-use hazard
        nxt; clr; load_hit(5, 0); exceptionM = 1; #2;
        chk("exlu_flush", flv, 4'b1111);
        chk("exlu_stall", stv, 0);
        nxt; clr; #2;
        chk("exlu2_stall", stv, 0);
        chk("exlu2_flush", flv, 0);
        chk("exlu2_cnt", stall_cnt, 11);

        // ---- reset during pending flush
        nxt; clr; exceptionM = 1; d_cache_stall = 1; #2;
        chk("fp1_flush", flv, 0);
        nxt; clr; d_cache_stall = 1; #2;
        chk("fp2_stall", stv, 5'b11111);
        nxt; rst = 1; #2;
        chk("fp_rst_stall", stv, 0);
        chk("fp_rst_cnt", stall_cnt, 0);
        chk("fp_rst_cnt2", cnt2, 0);
        nxt; rst = 0; clr; #2;
        chk("fp_rel_flush", flv, 0);
        chk("fp_rel_stall", stv, 0);
        nxt; #2;
        chk("fp_rel2_flush", flv, 0);
        chk("fp_rel2_cnt", stall_cnt, 0);

        // ---- reset during an active load-use bubble
        nxt; clr; load_hit(9, 0); #2;
        chk("rlu1_stall", stv, 5'b11110);
        nxt; clr; rst = 1; #2;
        chk("rlu_rst_stall", stv, 0);
        nxt; rst = 0; #2;
        chk("rlu_rel_stall", stv, 0);
        chk("rlu_rel_flush", flv, 0);
        chk("rlu_rel_cnt", stall_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter LOAD_LAT, default 1, legal range 1..4: bubble cycles inserted per load-use hazard.
REQ-003 Parameter CNT_W, default 32: width of the stall-cycle counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 i_cache_stall, d_cache_stall, div_stall  in  1 each  long-stall requests.
REQ-007 rsD, rtD, rsE, rtE  in  REG_AW each  source registers in decode and execute.
REQ-008 reg_write_enE/M/W  in  1 each; reg_writeE/M/W  in  REG_AW each  destination per stage.
REQ-009 mem_read_enE, mem_read_enM  in  1 each  load in execute / memory.
REQ-010 exceptionM  in  1  exception detected in memory stage, one-cycle pulse.
REQ-011 stallF, stallD, stallE, stallM, stallW  out  1 each  pipeline-register hold.
REQ-012 flushF, flushD, flushE, flushM  out  1 each  pipeline-register clear.
REQ-013 forward_aE, forward_bE  out  2 each  00 none, 01 from MEM, 10 from WB.
REQ-014 stall_cnt  out  CNT_W  cycles in which stallF was asserted.

Function
REQ-015 Forwarding is combinational: MEM source has priority over WB; register 0 is never forwarded, for both operands.
REQ-016 MEM forwarding requires reg_write_enM=1 and mem_read_enM=0; a load in MEM forwards only from WB.
REQ-017 long = i_cache_stall | d_cache_stall | div_stall; stallF/D/E/M = long | lu_stall; stallW = d_cache_stall.
REQ-018 lu_hit: mem_read_enE & reg_write_enE & reg_writeE!=0 & (reg_writeE==rsD | reg_writeE==rtD).
REQ-019 States: IDLE, LU, FLUSH_PEND.
REQ-020 IDLE -> LU on lu_hit with long=0 and no flush this cycle; bubble counter loaded with LOAD_LAT-1.
REQ-021 lu_stall is asserted in the lu_hit cycle and in each LU-state cycle; stallF and stallD are held and flushE=1 (bubble) in each such cycle unless long=1.
REQ-022 In LU, the counter decrements when long=0 and holds when long=1; LU -> IDLE when it reads 0 with long=0.
REQ-023 Total bubbles per hazard equal LOAD_LAT exactly, regardless of interleaved long stalls.
REQ-024 exceptionM with long=0: flushF/D/E/M=1 in the same cycle, all stalls forced 0 that cycle, state -> IDLE (an active LU is cancelled).
REQ-025 exceptionM with long=1: state -> FLUSH_PEND, no flush; the flush of REQ-024 is issued in the first cycle with long=0, then -> IDLE.
REQ-026 A new exceptionM while in FLUSH_PEND is absorbed; a single flush is issued.
REQ-027 In FLUSH_PEND, lu_hit is ignored.
REQ-028 stall_cnt increments by 1 on each edge where stallF=1 and saturates at all-ones.

Reset
REQ-029 While rst=1: state IDLE, bubble counter 0, stall_cnt 0; all stall, flush and forward outputs 0.
REQ-030 Assertion of rst mid-LU or mid-FLUSH_PEND discards the pending bubble or flush; the first cycle after release behaves as IDLE.

Verification
REQ-031 rsE=3, reg_write_enM=1, reg_writeM=3, reg_write_enW=1, reg_writeW=3 -> forward_aE=01; set mem_read_enM=1 -> 10; rsE=0 -> 00.
REQ-032 LOAD_LAT=2, load writing r5 in E, rsD=5 -> stallF=stallD=flushE=1 for exactly 2 cycles, stall_cnt +2.
REQ-033 LOAD_LAT=2, div_stall=1 for 3 cycles starting at the second bubble cycle -> flushE=0 during the div stall, exactly 2 bubble cycles in total, stall_cnt +5.
REQ-034 exceptionM pulse with d_cache_stall=1 for 4 cycles -> no flush for 4 cycles, flushF..M=1 for one cycle on the 5th, then IDLE.
REQ-035 exceptionM coincident with lu_hit -> flush only, no bubble; rst pulse during FLUSH_PEND -> no flush after release, stall_cnt=0.
